// File: rtl/fpmul_arbiter_pkg.sv
// fpmul_arb_pkg: shared types and helpers for the multiplier arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   idx_width() : width of a requester index for a given requester count
package fpmul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpmul_arbiter_if.sv
// fpmul_arbiter_if: requester and multiplier val/rdy channels of the arbiter.
//   req_*  : per-requester operand channel (val/rdy, a, b)
//   resp_* : per-requester product channel (val/rdy, shared c)
//   mul_*  : snd/rcv channels towards the single shared multiplier
// Modports: slave = the arbiter, master = requesters plus multiplier.
interface fpmul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int N    = 32
);
  logic [NREQ-1:0]        req_val;
  logic [NREQ-1:0]        req_rdy;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic [NREQ-1:0]        resp_val;
  logic [NREQ-1:0]        resp_rdy;
  logic [N-1:0]           resp_c;
  logic                   mul_snd_val;
  logic                   mul_snd_rdy;
  logic [N-1:0]           mul_a;
  logic [N-1:0]           mul_b;
  logic                   mul_rcv_val;
  logic                   mul_rcv_rdy;
  logic [N-1:0]           mul_c;

  modport slave (
    input  req_val, req_a, req_b, resp_rdy, mul_snd_rdy, mul_rcv_val, mul_c,
    output req_rdy, resp_val, resp_c, mul_snd_val, mul_a, mul_b, mul_rcv_rdy
  );

  modport master (
    output req_val, req_a, req_b, resp_rdy, mul_snd_rdy, mul_rcv_val, mul_c,
    input  req_rdy, resp_val, resp_c, mul_snd_val, mul_a, mul_b, mul_rcv_rdy
  );
endinterface

// File: rtl/fpmul_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot grant, idx : binary index of grant, any : some request present
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk from the farthest offset down to ptr itself so the nearest
    // requester above ptr (with wrap) is the last one written and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[IW'(j)]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: shares one iterative fixed-point multiplier between NREQ
// requesters, one transaction in flight at a time, round-robin order.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : requester req/resp channels and multiplier snd/rcv channels
//   grant_id   : index of the current or most recent grant (debug)
//   busy       : high whenever the FSM is outside IDLE
//
// state | meaning
// IDLE  | pick next requester; also drains stale multiplier results
// ISSUE | present latched operands to the multiplier
// WAIT  | wait for the multiplier result
// RESP  | present product to the granted requester
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N    = 32,
  parameter int D    = 16,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic           clk,
  input  logic           reset,
  fpmul_arbiter_if.slave bus,
  output logic [IW-1:0]  grant_id,
  output logic           busy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;

  // D only describes the multiplier's number format; reject impossible values.
  if (D >= N) begin : g_bad_frac
    $error("fpmul_arbiter: D must be smaller than N");
  end

  logic [1:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [N-1:0]    res_c;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req (bus.req_val),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign bus.req_rdy     = (state == S_IDLE) ? pick_gnt : '0;
  assign bus.mul_snd_val = (state == S_ISSUE);
  assign bus.mul_a       = op_a;
  assign bus.mul_b       = op_b;
  // Ready in IDLE too, so a result orphaned by a reset gets swallowed.
  assign bus.mul_rcv_rdy = (state == S_IDLE) || (state == S_WAIT);
  assign bus.resp_c      = res_c;
  assign busy            = (state != S_IDLE);

  always_comb begin
    bus.resp_val           = '0;
    bus.resp_val[grant_id] = (state == S_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_c    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            op_a     <= bus.req_a[pick_idx];
            op_b     <= bus.req_b[pick_idx];
            grant_id <= pick_idx;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mul_snd_rdy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_rcv_val) begin
            res_c <= bus.mul_c;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          // Pointer moves only once the product is delivered.
          if (bus.resp_rdy[grant_id]) begin
            rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
module tb_fpmul_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int D    = 16;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] grant_id;
  logic          busy;

  fpmul_arbiter_if #(.NREQ(NREQ), .N(N)) ifc();

  fpmul_arbiter #(.NREQ(NREQ), .N(N), .D(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Signed Qx.D multiply, truncated: what the stub multiplier returns.
  function automatic logic [N-1:0] fxmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
    return p[D +: N];
  endfunction

  // ---------------- stub multiplier (never reset by the arbiter) ----------------
  int           stub_lat  = 5;
  bit           snd_stall = 1'b0;
  bit           stub_busy = 1'b0;
  int           stub_cnt  = 0;
  logic [N-1:0] stub_c    = '0;

  always @(posedge clk) begin
    if (ifc.mul_snd_val && ifc.mul_snd_rdy) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat - 1;
      stub_c    <= fxmul(ifc.mul_a, ifc.mul_b);
    end else if (stub_busy && stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_busy && ifc.mul_rcv_rdy) begin
      stub_busy <= 1'b0;
    end
  end

  assign ifc.mul_snd_rdy = !stub_busy && !snd_stall;
  assign ifc.mul_rcv_val = stub_busy && (stub_cnt == 0);
  assign ifc.mul_c       = stub_c;

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct {
    int           id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
  } txn_t;

  txn_t            sb[$];
  txn_t            mon_t;
  int              grant_log[$];
  int              model_ptr = 0;
  bit              inflight  = 1'b0;
  bit              acc[NREQ];
  int              win, mon_j;
  logic [NREQ-1:0] exp_rdy;
  logic [NREQ-1:0] exp_onehot;
  bit              prev_snd_pend = 1'b0;
  bit              prev_resp_any = 1'b0;
  bit              prev_resp_pend = 1'b0;
  int              fire_cyc_last = 0;
  int              resp_cyc_last = 0;
  logic [N-1:0]    last_c = '0;
  int              n_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      model_ptr      = 0;
      inflight       = 1'b0;
      prev_snd_pend  = 1'b0;
      prev_resp_any  = 1'b0;
      prev_resp_pend = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_snd_val", ifc.mul_snd_val, 0);
      chk("rst_rcv_rdy", ifc.mul_rcv_rdy, 1);
      chk("rst_resp_val", ifc.resp_val, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_ops", {ifc.mul_a, ifc.mul_b}, 0);
      chk("rst_resp_c", ifc.resp_c, 0);
      if (ifc.req_val == '0) chk("rst_req_rdy", ifc.req_rdy, 0);
    end else begin
      // Expected grant: first valid requester at or above the pointer, wrapping.
      win     = -1;
      exp_rdy = '0;
      if (!inflight) begin
        for (int k = 0; k < NREQ; k++) begin
          mon_j = (model_ptr + k) % NREQ;
          if (win < 0 && ifc.req_val[mon_j]) win = mon_j;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_rdy", ifc.req_rdy, exp_rdy);
      chk("busy", busy, inflight);

      if (sb.size() == 0) begin
        chk("spurious_snd", ifc.mul_snd_val, 0);
      end else if (ifc.mul_snd_val) begin
        chk("mul_a", ifc.mul_a, sb[0].a);
        chk("mul_b", ifc.mul_b, sb[0].b);
      end
      if (prev_snd_pend) chk("snd_held", ifc.mul_snd_val, 1);
      prev_snd_pend = ifc.mul_snd_val && !ifc.mul_snd_rdy;

      if (sb.size() == 0) begin
        chk("spurious_resp", ifc.resp_val, 0);
        prev_resp_pend = 1'b0;
      end else begin
        if (prev_resp_pend) chk("resp_held", ifc.resp_val != '0, 1);
        prev_resp_pend = 1'b0;
        if (ifc.resp_val != '0) begin
          exp_onehot = '0;
          exp_onehot[sb[0].id] = 1'b1;
          chk("resp_val", ifc.resp_val, exp_onehot);
          chk("resp_c", ifc.resp_c, sb[0].c);
          if (!prev_resp_any) resp_cyc_last = cyc;
          if (ifc.resp_rdy[sb[0].id]) begin
            model_ptr = (sb[0].id + 1) % NREQ;
            inflight  = 1'b0;
            last_c    = ifc.resp_c;
            n_done++;
            void'(sb.pop_front());
          end else begin
            prev_resp_pend = 1'b1;
          end
        end
      end
      prev_resp_any = (ifc.resp_val != '0);

      if (win >= 0) begin
        mon_t.id = win;
        mon_t.a  = ifc.req_a[win];
        mon_t.b  = ifc.req_b[win];
        mon_t.c  = fxmul(ifc.req_a[win], ifc.req_b[win]);
        sb.push_back(mon_t);
        grant_log.push_back(win);
        inflight      = 1'b1;
        acc[win]      = 1'b1;
        fire_cyc_last = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  bit cont_mode = 1'b0;
  bit rand_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (cont_mode) begin
          ifc.req_a[i] = $urandom;
          ifc.req_b[i] = $urandom;
        end else begin
          ifc.req_val[i] = 1'b0;
        end
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!ifc.req_val[i] && $urandom_range(0, 3) == 0) begin
          ifc.req_val[i] = 1'b1;
          ifc.req_a[i]   = $urandom;
          ifc.req_b[i]   = $urandom;
        end
      end
      ifc.resp_rdy = 4'($urandom);
      snd_stall    = ($urandom_range(0, 3) == 0);
      stub_lat     = $urandom_range(1, 6);
    end
  endtask

  task automatic req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    ifc.req_val[i] = 1'b1;
    ifc.req_a[i]   = a;
    ifc.req_b[i]   = b;
  endtask

  task automatic drain(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      if (ifc.req_val == '0 && sb.size() == 0 && !busy) break;
      tick();
    end
    chk("drain", (ifc.req_val == '0 && sb.size() == 0 && !busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  logic [N-1:0] ta, tb;
  int           base;
  int           exp_order[5] = '{0, 1, 2, 3, 0};
  int           exp_rereq[3] = '{3, 0, 2};

  initial begin
    ifc.req_val  = '0;
    ifc.req_a    = '0;
    ifc.req_b    = '0;
    ifc.resp_rdy = '1;
    reset        = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single requester, L=5: response appears 7 cycles after the fire cycle.
    stub_lat = 5;
    req(1, 32'h0002_0000, 32'h0003_0000);
    drain(50);
    chk("single_latency", resp_cyc_last - fire_cyc_last, 7);
    chk("single_grant", grant_log[$], 1);
    chk("single_c", last_c, 32'h0006_0000);

    // Fairness: everyone requesting straight out of reset.
    reset     = 1'b1;
    cont_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) req(i, $urandom, $urandom);
    tick();
    tick();
    base  = grant_log.size();
    reset = 1'b0;
    for (int k = 0; k < 300 && grant_log.size() < base + 5; k++) tick();
    cont_mode   = 1'b0;
    ifc.req_val = '0;
    chk("fair_count", grant_log.size() >= base + 5, 1);
    for (int k = 0; k < 5; k++)
      if (grant_log.size() > base + k) chk("fair_order", grant_log[base + k], exp_order[k]);
    drain(100);

    // Response backpressure: product held, nobody else granted.
    ifc.resp_rdy = '0;
    ta = $urandom;
    tb = $urandom;
    req(2, ta, tb);
    for (int k = 0; k < 50 && ifc.resp_val == '0; k++) tick();
    chk("bp_resp_seen", ifc.resp_val, 4'b0100);
    req(0, $urandom, $urandom);
    repeat (10) begin
      tick();
      chk("bp_resp_val", ifc.resp_val, 4'b0100);
      chk("bp_resp_c", ifc.resp_c, fxmul(ta, tb));
      chk("bp_req_rdy", ifc.req_rdy, 0);
    end
    ifc.resp_rdy = '1;
    drain(100);
    chk("bp_next_grant", grant_log[$], 0);

    // Multiplier backpressure: operands held in ISSUE.
    snd_stall = 1'b1;
    ta = $urandom;
    tb = $urandom;
    req(3, ta, tb);
    for (int k = 0; k < 20 && !ifc.mul_snd_val; k++) tick();
    repeat (3) begin
      tick();
      chk("stall_snd_val", ifc.mul_snd_val, 1);
      chk("stall_mul_a", ifc.mul_a, ta);
      chk("stall_mul_b", ifc.mul_b, tb);
    end
    snd_stall = 1'b0;
    drain(100);

    // Reset while waiting on the multiplier; stale result must be swallowed.
    stub_lat = 8;
    req(0, $urandom, $urandom);
    for (int k = 0; k < 20 && !(busy && ifc.mul_rcv_rdy); k++) tick();
    chk("rst_wait_reached", busy && ifc.mul_rcv_rdy, 1);
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 30 && stub_busy; k++) tick();
    chk("stale_flushed", stub_busy, 0);
    chk("stale_no_resp", ifc.resp_val, 0);
    stub_lat = 3;
    req(1, 32'hFFFF_0000, 32'h0004_8000);
    drain(100);
    chk("post_rst_grant", grant_log[$], 1);
    chk("post_rst_c", last_c, 32'hFFFB_8000);

    // Re-request during own response.
    ifc.resp_rdy = '0;
    req(2, $urandom, $urandom);
    for (int k = 0; k < 50 && ifc.resp_val == '0; k++) tick();
    base = grant_log.size();
    req(2, $urandom, $urandom);
    req(0, $urandom, $urandom);
    req(3, $urandom, $urandom);
    repeat (3) begin
      tick();
      chk("rereq_blocked", ifc.req_rdy, 0);
    end
    ifc.resp_rdy = '1;
    drain(200);
    chk("rereq_count", grant_log.size() - base, 3);
    for (int k = 0; k < 3; k++)
      if (grant_log.size() > base + k) chk("rereq_order", grant_log[base + k], exp_rereq[k]);

    // Random traffic against the model.
    base      = n_done;
    rand_mode = 1'b1;
    repeat (2000) tick();
    rand_mode    = 1'b0;
    snd_stall    = 1'b0;
    ifc.resp_rdy = '1;
    drain(500);
    chk("rand_progress", (n_done - base) > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
